// File: rtl/ext_alu_sched_pkg.sv
// Shared definitions for the extended-ALU sequencer: function codes,
// default latencies, FSM state encoding and the captured result payload.
package ext_alu_sched_pkg;

    localparam int unsigned FUNC_W = 3;
    localparam int unsigned DST_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PERF_W = 32;

    // Extended ALU function codes (value 7 is unassigned)
    localparam logic [FUNC_W-1:0] FN_MUL  = 3'd0;
    localparam logic [FUNC_W-1:0] FN_UMUL = 3'd1;
    localparam logic [FUNC_W-1:0] FN_ADDF = 3'd2;
    localparam logic [FUNC_W-1:0] FN_SUBF = 3'd3;
    localparam logic [FUNC_W-1:0] FN_MULF = 3'd4;
    localparam logic [FUNC_W-1:0] FN_ITF  = 3'd5;
    localparam logic [FUNC_W-1:0] FN_FTI  = 3'd6;

    // Default unit latencies, start pulse to result valid
    localparam int unsigned DEF_MUL_LAT  = 3;
    localparam int unsigned DEF_FADD_LAT = 4;
    localparam int unsigned DEF_FMUL_LAT = 4;
    localparam int unsigned DEF_CVT_LAT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ext_state_e;

    // Result payload handed to EX_DM
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [DST_W-1:0]  dst;
        logic              z;
        logic              n;
        logic              v;
    } ext_res_t;

    // Arithmetic ops update Z/N/V; conversions and unknown codes do not
    function automatic logic writes_flags(input logic [FUNC_W-1:0] f);
        logic wf;
        case (f)
            FN_MUL, FN_UMUL, FN_ADDF, FN_SUBF, FN_MULF: wf = 1'b1;
            default:                                   wf = 1'b0;
        endcase
        return wf;
    endfunction

endpackage

// File: rtl/ext_lat_timer.sv
// Loadable down-counter timing the remaining cycles of an ext op.
module ext_lat_timer #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    input  logic             clr,
    output logic             zero_c
);

    logic [CNT_W-1:0] cnt;

    // Load has priority; decrement stops at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (clr) begin
            cnt <= '0;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/ext_alu_sched.sv
// Extended-ALU sequencer: starts the multi-cycle unit, times its latency,
// stalls the front of the pipe and emits a one-cycle result pulse.
// Optional counters enabled by defining EXT_SCHED_PERF_EN.
module ext_alu_sched
    import ext_alu_sched_pkg::*;
#(
    parameter int unsigned MUL_LAT  = DEF_MUL_LAT,
    parameter int unsigned FADD_LAT = DEF_FADD_LAT,
    parameter int unsigned FMUL_LAT = DEF_FMUL_LAT,
    parameter int unsigned CVT_LAT  = DEF_CVT_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ext_req,
    input  logic [FUNC_W-1:0] ext_func,
    input  logic [DST_W-1:0]  ext_dst,
    input  logic              kill,
    output logic              unit_start,
    output logic [FUNC_W-1:0] unit_func,
    output logic              unit_abort,
    input  logic [DATA_W-1:0] unit_result,
    input  logic              unit_z,
    input  logic              unit_n,
    input  logic              unit_v,
    output logic              stall_ext,
    output logic              busy,
    output logic              res_vld,
    output logic [DATA_W-1:0] res_data,
    output logic [DST_W-1:0]  res_dst,
    output logic              res_z,
    output logic              res_n,
    output logic              res_v,
    output logic              flag_we,
    output logic [PERF_W-1:0] perf_ops,
    output logic [PERF_W-1:0] perf_stall
);

    localparam int unsigned MAX_LAT_A = (MUL_LAT > FADD_LAT) ? MUL_LAT : FADD_LAT;
    localparam int unsigned MAX_LAT_B = (FMUL_LAT > CVT_LAT) ? FMUL_LAT : CVT_LAT;
    localparam int unsigned MAX_LAT   = (MAX_LAT_A > MAX_LAT_B) ? MAX_LAT_A : MAX_LAT_B;
    localparam int unsigned CNT_W     = int'($clog2(MAX_LAT)) + 1;

    // Latency minus one for the counter preload; unknown codes take one cycle
    function automatic logic [CNT_W-1:0] lat_m1(input logic [FUNC_W-1:0] f);
        logic [CNT_W-1:0] v;
        case (f)
            FN_MUL, FN_UMUL: v = CNT_W'(MUL_LAT - 1);
            FN_ADDF, FN_SUBF: v = CNT_W'(FADD_LAT - 1);
            FN_MULF:         v = CNT_W'(FMUL_LAT - 1);
            FN_ITF, FN_FTI:  v = CNT_W'(CVT_LAT - 1);
            default:         v = '0;
        endcase
        return v;
    endfunction

    ext_state_e        state_q, state_nxt;
    logic [FUNC_W-1:0] func_q;
    logic [DST_W-1:0]  dst_q;
    ext_res_t          res_q;
    logic              req_ok;
    logic              accept, capture;
    logic              start_nxt, abort_nxt, vld_nxt, fwe_nxt;
    logic              tmr_dec, tmr_clr, tmr_zero;

    assign req_ok = ext_req & ~kill;

    ext_lat_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (lat_m1(ext_func)),
        .dec      (tmr_dec),
        .clr      (tmr_clr),
        .zero_c   (tmr_zero)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state and next values of the registered pulses; kill beats completion
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        capture   = 1'b0;
        start_nxt = 1'b0;
        abort_nxt = 1'b0;
        vld_nxt   = 1'b0;
        fwe_nxt   = 1'b0;
        tmr_dec   = 1'b0;
        tmr_clr   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    accept    = 1'b1;
                    start_nxt = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (kill) begin
                    abort_nxt = 1'b1;
                    tmr_clr   = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (tmr_zero) begin
                    capture   = 1'b1;
                    vld_nxt   = 1'b1;
                    fwe_nxt   = writes_flags(func_q);
                    state_nxt = ST_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_DONE: begin
                if (req_ok) begin
                    accept    = 1'b1;
                    start_nxt = 1'b1;
                    state_nxt = ST_BUSY;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pipe stall: a new accepted request or an op in flight
    assign stall_ext = (state_q == ST_BUSY) |
                       (((state_q == ST_IDLE) | (state_q == ST_DONE)) & req_ok);

    // Registered unit controls, latched op and captured result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_start <= 1'b0;
            unit_abort <= 1'b0;
            res_vld    <= 1'b0;
            flag_we    <= 1'b0;
            busy       <= 1'b0;
            func_q     <= '0;
            dst_q      <= '0;
            res_q      <= '0;
        end else begin
            unit_start <= start_nxt;
            unit_abort <= abort_nxt;
            res_vld    <= vld_nxt;
            flag_we    <= fwe_nxt;
            busy       <= (state_nxt != ST_IDLE);
            if (accept) begin
                func_q <= ext_func;
                dst_q  <= ext_dst;
            end
            if (capture) begin
                res_q <= '{data: unit_result, dst: dst_q, z: unit_z, n: unit_n, v: unit_v};
            end
        end
    end

    assign unit_func = func_q;
    assign res_data  = res_q.data;
    assign res_dst   = res_q.dst;
    assign res_z     = res_q.z;
    assign res_n     = res_q.n;
    assign res_v     = res_q.v;

`ifdef EXT_SCHED_PERF_EN
    logic [PERF_W-1:0] ops_q, stall_q;

    // Saturating completion and stall counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_q   <= '0;
            stall_q <= '0;
        end else begin
            if (res_vld && (ops_q != '1)) begin
                ops_q <= ops_q + PERF_W'(1);
            end
            if (stall_ext && (stall_q != '1)) begin
                stall_q <= stall_q + PERF_W'(1);
            end
        end
    end

    assign perf_ops   = ops_q;
    assign perf_stall = stall_q;
`else
    assign perf_ops   = '0;
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_ext_alu_sched.sv
// Self-checking bench for ext_alu_sched with a cycle-timeline reference model.
module tb_ext_alu_sched;

    localparam int MUL_L  = 3;
    localparam int FADD_L = 4;
    localparam int FMUL_L = 4;
    localparam int CVT_L  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ext_req = 1'b0;
    logic [2:0]  ext_func = 3'd0;
    logic [4:0]  ext_dst = 5'd0;
    logic        kill = 1'b0;
    logic        unit_start;
    logic [2:0]  unit_func;
    logic        unit_abort;
    logic [31:0] unit_result = 32'd0;
    logic        unit_z = 1'b0;
    logic        unit_n = 1'b0;
    logic        unit_v = 1'b0;
    logic        stall_ext;
    logic        busy;
    logic        res_vld;
    logic [31:0] res_data;
    logic [4:0]  res_dst;
    logic        res_z, res_n, res_v;
    logic        flag_we;
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;

    int tests = 0;
    int fails = 0;

    // Reference model state: last captured result, last latched func, perf totals
    logic [31:0] m_data = 32'd0;
    logic [4:0]  m_dst = 5'd0;
    logic [2:0]  m_znv = 3'd0;
    logic [2:0]  m_func = 3'd0;
    int          m_ops = 0;
    int          m_stall = 0;

    ext_alu_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ext_req     (ext_req),
        .ext_func    (ext_func),
        .ext_dst     (ext_dst),
        .kill        (kill),
        .unit_start  (unit_start),
        .unit_func   (unit_func),
        .unit_abort  (unit_abort),
        .unit_result (unit_result),
        .unit_z      (unit_z),
        .unit_n      (unit_n),
        .unit_v      (unit_v),
        .stall_ext   (stall_ext),
        .busy        (busy),
        .res_vld     (res_vld),
        .res_data    (res_data),
        .res_dst     (res_dst),
        .res_z       (res_z),
        .res_n       (res_n),
        .res_v       (res_v),
        .flag_we     (flag_we),
        .perf_ops    (perf_ops),
        .perf_stall  (perf_stall)
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input logic [2:0] f);
        case (f)
            3'd0, 3'd1: return MUL_L;
            3'd2, 3'd3: return FADD_L;
            3'd4:       return FMUL_L;
            3'd5, 3'd6: return CVT_L;
            default:    return 1;
        endcase
    endfunction

    function automatic bit flags_of(input logic [2:0] f);
        return (f <= 3'd4);
    endfunction

    task automatic test_reset();
        logic [89:0] got;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        got = {unit_start, unit_func, unit_abort, stall_ext, busy, res_vld, res_data,
               res_dst, res_z, res_n, res_v, flag_we, perf_ops[15:0], perf_stall[15:0]};
        tests++;
        if (got !== '0) begin
            fails++;
            $display("FAIL reset_outputs got=%h exp=0", got);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One op from request through return to idle; kill_rel<0 means no kill,
    // 0 kills the request itself, 1..lat kills during the busy phase.
    task automatic run_op(input logic [2:0] f, input logic [4:0] d,
                          input int kill_rel, input bit hold);
        int lat;
        bit ignored, killed;
        logic [31:0] n_data;
        logic [2:0]  n_znv;
        logic [5:0]  e_ctl, g_ctl;
        logic [39:0] e_res, g_res;
        logic [2:0]  e_func;
        bit e_stall, e_start, e_abort, e_busy, e_vld, e_fwe;
        lat = lat_of(f);
        ignored = (kill_rel == 0);
        killed  = (kill_rel >= 1) && (kill_rel <= lat);
        n_data = 32'd0;
        n_znv  = 3'd0;
        for (int k = 0; k <= lat + 2; k++) begin
            @(posedge clk); #1;
            ext_req  = (k == 0) || (hold && k <= lat);
            ext_func = ext_req ? f : 3'($urandom);
            ext_dst  = ext_req ? d : 5'($urandom);
            kill     = (k == kill_rel);
            unit_result = $urandom;
            {unit_z, unit_n, unit_v} = 3'($urandom);
            if (k == lat) begin
                n_data = unit_result;
                n_znv  = {unit_z, unit_n, unit_v};
            end
            @(negedge clk);
            {e_stall, e_start, e_abort, e_busy, e_vld, e_fwe} = 6'b0;
            if (killed) begin
                e_stall = (k <= kill_rel);
                e_start = (k == 1);
                e_busy  = (k >= 1) && (k <= kill_rel);
                e_abort = (k == kill_rel + 1);
            end else if (!ignored) begin
                e_stall = (k <= lat);
                e_start = (k == 1);
                e_busy  = (k >= 1) && (k <= lat + 1);
                e_vld   = (k == lat + 1);
                e_fwe   = e_vld && flags_of(f);
            end
            e_ctl = {e_stall, e_start, e_abort, e_busy, e_vld, e_fwe};
            g_ctl = {stall_ext, unit_start, unit_abort, busy, res_vld, flag_we};
            tests++;
            if (g_ctl !== e_ctl) begin
                fails++;
                $display("FAIL op_ctl func=%0d k=%0d kill=%0d {stall,start,abort,busy,vld,fwe} got=%b exp=%b",
                         f, k, kill_rel, g_ctl, e_ctl);
            end
            if (!ignored && !killed && k >= lat + 1) e_res = {n_data, d, n_znv};
            else                                     e_res = {m_data, m_dst, m_znv};
            g_res = {res_data, res_dst, res_z, res_n, res_v};
            tests++;
            if (g_res !== e_res) begin
                fails++;
                $display("FAIL op_result func=%0d k=%0d got=%h exp=%h", f, k, g_res, e_res);
            end
            e_func = (!ignored && k >= 1) ? f : m_func;
            tests++;
            if (unit_func !== e_func) begin
                fails++;
                $display("FAIL op_unit_func k=%0d got=%0d exp=%0d", k, unit_func, e_func);
            end
        end
        if (!ignored) m_func = f;
        if (killed) begin
            m_stall += kill_rel + 1;
        end else if (!ignored) begin
            m_data = n_data; m_dst = d; m_znv = n_znv;
            m_ops++;
            m_stall += lat + 1;
        end
    endtask

    task automatic test_directed();
        run_op(3'd0, 5'd3, -1, 1'b1);   // MUL, request held through busy
        run_op(3'd5, 5'd7, -1, 1'b0);   // ITF, no flag write
        run_op(3'd7, 5'd9, -1, 1'b0);   // unrecognised code, latency 1
    endtask

    task automatic test_random_ops();
        for (int i = 0; i < 24; i++) begin
            logic [2:0] f;
            int kr;
            bit h;
            f  = 3'($urandom);
            kr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat_of(f)) : -1;
            h  = (kr < 0) && ($urandom_range(0, 1) == 1);
            run_op(f, 5'($urandom), kr, h);
        end
    endtask

    task automatic test_kill();
        run_op(3'd2, 5'd11, 2, 1'b0);      // ADDF killed in second busy cycle
        run_op(3'd0, 5'd12, MUL_L, 1'b0);  // kill coincident with last count
        run_op(3'd4, 5'd13, 0, 1'b0);      // kill alongside the request
        run_op(3'd6, 5'd14, 1, 1'b0);      // kill in first busy cycle
    endtask

    // ADDF then MULF requested in the DONE cycle of the first
    task automatic test_back_to_back();
        int la, lb, dn;
        logic [4:0]  da, db;
        logic [31:0] ra, rb;
        logic [2:0]  za, zb;
        logic [5:0]  e_ctl, g_ctl;
        logic [39:0] e_res, g_res;
        logic [2:0]  e_func;
        bit e_vld;
        la = lat_of(3'd2);
        lb = lat_of(3'd4);
        dn = la + 1;
        da = 5'($urandom);
        db = 5'($urandom);
        ra = 32'd0; rb = 32'd0; za = 3'd0; zb = 3'd0;
        for (int k = 0; k <= dn + lb + 2; k++) begin
            @(posedge clk); #1;
            ext_req  = (k == 0) || (k == dn);
            ext_func = (k == 0) ? 3'd2 : (k == dn) ? 3'd4 : 3'($urandom);
            ext_dst  = (k == 0) ? da : (k == dn) ? db : 5'($urandom);
            kill     = 1'b0;
            unit_result = $urandom;
            {unit_z, unit_n, unit_v} = 3'($urandom);
            if (k == la)      begin ra = unit_result; za = {unit_z, unit_n, unit_v}; end
            if (k == dn + lb) begin rb = unit_result; zb = {unit_z, unit_n, unit_v}; end
            @(negedge clk);
            e_vld = (k == dn) || (k == dn + lb + 1);
            e_ctl = {k <= dn + lb, (k == 1) || (k == dn + 1), 1'b0,
                     (k >= 1) && (k <= dn + lb + 1), e_vld, e_vld};
            g_ctl = {stall_ext, unit_start, unit_abort, busy, res_vld, flag_we};
            tests++;
            if (g_ctl !== e_ctl) begin
                fails++;
                $display("FAIL b2b_ctl k=%0d {stall,start,abort,busy,vld,fwe} got=%b exp=%b", k, g_ctl, e_ctl);
            end
            if (k < dn)               e_res = {m_data, m_dst, m_znv};
            else if (k <= dn + lb)    e_res = {ra, da, za};
            else                      e_res = {rb, db, zb};
            g_res = {res_data, res_dst, res_z, res_n, res_v};
            tests++;
            if (g_res !== e_res) begin
                fails++;
                $display("FAIL b2b_result k=%0d got=%h exp=%h", k, g_res, e_res);
            end
            e_func = (k == 0) ? m_func : (k <= dn) ? 3'd2 : 3'd4;
            tests++;
            if (unit_func !== e_func) begin
                fails++;
                $display("FAIL b2b_unit_func k=%0d got=%0d exp=%0d", k, unit_func, e_func);
            end
        end
        m_data = rb; m_dst = db; m_znv = zb; m_func = 3'd4;
        m_ops += 2;
        m_stall += dn + lb + 1;
    endtask

    // Asynchronous reset in the middle of an op clears state without any pulse
    task automatic test_mid_reset();
        logic [6:0] g;
        @(posedge clk); #1;
        ext_req = 1'b1; ext_func = 3'd2; ext_dst = 5'd21; kill = 1'b0;
        @(posedge clk); #1;
        ext_req = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        g = {unit_start, unit_abort, stall_ext, busy, res_vld, flag_we, |res_data};
        tests++;
        if (g !== 7'b0) begin
            fails++;
            $display("FAIL mid_reset_async got=%b exp=0", g);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_data = 32'd0; m_dst = 5'd0; m_znv = 3'd0; m_func = 3'd0;
        m_ops = 0; m_stall = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            g = {unit_start, unit_abort, stall_ext, busy, res_vld, flag_we, 1'b0};
            tests++;
            if (g !== 7'b0) begin
                fails++;
                $display("FAIL mid_reset_quiet k=%0d got=%b exp=0", k, g);
            end
        end
    endtask

    task automatic test_perf();
        int e_ops, e_stall;
`ifdef EXT_SCHED_PERF_EN
        e_ops = m_ops;
        e_stall = m_stall;
`else
        e_ops = 0;
        e_stall = 0;
`endif
        @(negedge clk);
        tests++;
        if (perf_ops !== 32'(e_ops)) begin
            fails++;
            $display("FAIL perf_ops got=%0d exp=%0d", perf_ops, e_ops);
        end
        tests++;
        if (perf_stall !== 32'(e_stall)) begin
            fails++;
            $display("FAIL perf_stall got=%0d exp=%0d", perf_stall, e_stall);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_ops();
        test_kill();
        test_back_to_back();
        test_perf();
        test_mid_reset();
        run_op(3'd0, 5'd1, -1, 1'b0);
        run_op(3'd0, 5'd2, -1, 1'b0);
        test_perf();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
